// File: rtl/step_pulse_gen.sv
// Synthetic step-pulse source: a phase accumulator produces exactly RATE rising
// edges of PULSE per CLK_HZ cycles, alongside a strobe and a seconds timeline.
module step_pulse_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int ACC_W  = $clog2(2*CLK_HZ)
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [1:0] MODE,
    output logic       PULSE,
    output logic       STEP_STROBE,
    output logic       SEC_TICK,
    output logic [7:0] ELAPSED_SEC,
    output logic [7:0] RATE
);
    localparam int CYC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [ACC_W-1:0] HZ   = ACC_W'(CLK_HZ);
    localparam logic [ACC_W-1:0] HALF = ACC_W'(CLK_HZ / 2);
    localparam logic [CYC_W-1:0] LAST = CYC_W'(CLK_HZ - 1);

    logic [ACC_W-1:0] acc, acc_sum, acc_next;
    logic [CYC_W-1:0] cyc;
    logic             pulse_next, sec_wrap;
    logic [7:0]       elapsed_next;

    // Hybrid profile is indexed by elapsed seconds; it goes silent from second 9.
    function automatic logic [7:0] rate_sel(input logic [1:0] mode, input logic [7:0] sec);
        logic [7:0] r;
        r = 8'd0;
        case (mode)
            2'b00: r = 8'd32;
            2'b01: r = 8'd64;
            2'b10: r = 8'd128;
            default: begin
                case (sec)
                    8'd0:    r = 8'd20;
                    8'd1:    r = 8'd33;
                    8'd2:    r = 8'd66;
                    8'd3:    r = 8'd27;
                    8'd4:    r = 8'd70;
                    8'd5:    r = 8'd30;
                    8'd6:    r = 8'd19;
                    8'd7:    r = 8'd30;
                    8'd8:    r = 8'd33;
                    default: r = 8'd0;
                endcase
            end
        endcase
        return r;
    endfunction

    always_comb begin
        acc_sum      = acc + ACC_W'(RATE);
        acc_next     = (acc_sum >= HZ) ? acc_sum - HZ : acc_sum;
        pulse_next   = (acc_next >= HALF);
        sec_wrap     = (cyc == LAST);
        elapsed_next = ELAPSED_SEC;
        if (sec_wrap && ELAPSED_SEC != 8'hFF)
            elapsed_next = ELAPSED_SEC + 8'd1;
    end

    // RATE is looked up from the next elapsed value so a hybrid step lands
    // exactly on the cycle after SEC_TICK.
    always_ff @(posedge CLK) begin
        if (!RESET || !START) begin
            acc         <= '0;
            cyc         <= '0;
            PULSE       <= 1'b0;
            STEP_STROBE <= 1'b0;
            SEC_TICK    <= 1'b0;
            ELAPSED_SEC <= 8'd0;
            RATE        <= rate_sel(MODE, 8'd0);
        end else begin
            acc         <= acc_next;
            cyc         <= sec_wrap ? '0 : cyc + CYC_W'(1);
            PULSE       <= pulse_next;
            STEP_STROBE <= pulse_next & ~PULSE;
            SEC_TICK    <= sec_wrap;
            ELAPSED_SEC <= elapsed_next;
            RATE        <= rate_sel(MODE, elapsed_next);
        end
    end
endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: CLK_HZ=1000 main instance plus a CLK_HZ=100
// instance that reaches ELAPSED_SEC saturation in a short run.
module tb_step_pulse_gen;
    logic       clk = 1'b0;
    logic       reset, start, start2;
    logic [1:0] mode;
    logic       pulse, step_strobe, sec_tick;
    logic [7:0] elapsed_sec, rate;
    logic       pulse2, step_strobe2, sec_tick2;
    logic [7:0] elapsed_sec2, rate2;

    int n_run = 0, n_fail = 0;
    int t, total, ticks, tick_bad, strobe_bad;
    int win [0:15];
    logic prev_pulse;

    always #5 clk = ~clk;

    step_pulse_gen #(.CLK_HZ(1000)) dut (
        .CLK(clk), .RESET(reset), .START(start), .MODE(mode),
        .PULSE(pulse), .STEP_STROBE(step_strobe), .SEC_TICK(sec_tick),
        .ELAPSED_SEC(elapsed_sec), .RATE(rate)
    );

    step_pulse_gen #(.CLK_HZ(100)) dut_sat (
        .CLK(clk), .RESET(reset), .START(start2), .MODE(2'b11),
        .PULSE(pulse2), .STEP_STROBE(step_strobe2), .SEC_TICK(sec_tick2),
        .ELAPSED_SEC(elapsed_sec2), .RATE(rate2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick_edge(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        t = 0; total = 0; ticks = 0; tick_bad = 0; strobe_bad = 0;
        for (int i = 0; i < 16; i++) win[i] = 0;
        prev_pulse = pulse;
    endtask

    // Advance n running cycles, binning strobes into 1000-cycle windows.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            t++;
            if (step_strobe) begin
                total++;
                if ((t - 1) / 1000 < 16) win[(t - 1) / 1000]++;
            end
            if (step_strobe !== (pulse & ~prev_pulse)) strobe_bad++;
            if (sec_tick) begin
                ticks++;
                if (t % 1000 != 0) tick_bad++;
            end
            prev_pulse = pulse;
        end
    endtask

    task automatic idle_with_mode(input logic [1:0] m);
        start = 1'b0;
        mode  = m;
        tick_edge(1);
    endtask

    int hyb [0:11] = '{20, 33, 66, 27, 70, 30, 19, 30, 33, 0, 0, 0};
    int n_edges, sat_ticks;

    initial begin
        reset = 1'b0; start = 1'b1; start2 = 1'b0; mode = 2'b10;
        tick_edge(3);
        chk("rst_pulse",  pulse, 0);
        chk("rst_strobe", step_strobe, 0);
        chk("rst_tick",   sec_tick, 0);
        chk("rst_elapsed", elapsed_sec, 0);
        chk("rst_rate",   rate, 128);

        // walk
        reset = 1'b1;
        idle_with_mode(2'b00);
        chk("walk_idle_rate", rate, 32);
        start = 1'b1;
        clr();
        run(3000);
        for (int i = 0; i < 3; i++) chk($sformatf("walk_win%0d", i), win[i], 32);
        chk("walk_total", total, 96);
        chk("walk_elapsed", elapsed_sec, 3);
        chk("walk_ticks", ticks, 3);
        chk("walk_tick_pos", tick_bad, 0);
        chk("walk_strobe_align", strobe_bad, 0);

        // run then jog; the switch is sampled on the last cycle of second 0
        idle_with_mode(2'b10);
        start = 1'b1;
        clr();
        run(999);
        mode = 2'b01;
        run(1001);
        chk("run_win0", win[0], 128);
        chk("jog_win1", win[1], 64);
        chk("jog_rate", rate, 64);
        chk("runjog_strobe_align", strobe_bad, 0);

        // hybrid
        idle_with_mode(2'b11);
        chk("hyb_idle_rate", rate, 20);
        start = 1'b1;
        clr();
        run(12000);
        for (int i = 0; i < 12; i++) chk($sformatf("hyb_win%0d", i), win[i], hyb[i]);
        chk("hyb_total", total, 328);
        chk("hyb_rate_end", rate, 0);
        chk("hyb_elapsed", elapsed_sec, 12);
        chk("hyb_ticks", ticks, 12);

        // abort and restart
        idle_with_mode(2'b00);
        start = 1'b1;
        clr();
        run(1490);
        chk("abort_pre_pulse", pulse, 1);
        run(10);
        chk("abort_pre_elapsed", elapsed_sec, 1);
        start = 1'b0;
        tick_edge(1);
        chk("abort_elapsed", elapsed_sec, 0);
        chk("abort_pulse", pulse, 0);
        chk("abort_tick", sec_tick, 0);
        tick_edge(499);
        start = 1'b1;
        n_edges = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (pulse) begin
                n_edges = i;
                break;
            end
        end
        chk("restart_first_rise", n_edges, 16);
        chk("restart_elapsed", elapsed_sec, 0);

        // saturation on the 100-cycle-per-second instance
        start2 = 1'b1;
        tick_edge(25400);
        chk("sat_elapsed_254", elapsed_sec2, 254);
        tick_edge(100);
        chk("sat_elapsed_255", elapsed_sec2, 255);
        chk("sat_rate", rate2, 0);
        sat_ticks = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (sec_tick2) sat_ticks++;
        end
        chk("sat_ticks", sat_ticks, 10);
        chk("sat_hold", elapsed_sec2, 255);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
